// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the prefix-adder leaf cells.
package arith_pkg;

  // Generate/propagate pair carried through every prefix level.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of prefix levels needed to span n bits: ceil(log2(n)).
  // A single bit needs no prefix levels, so n <= 1 yields 0.
  function automatic int unsigned clog2_min0(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone black cell: merges a higher (G,P) span with the adjacent
// lower span into one combined (G,P) span.
module ks_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  // Combined span generates if the high part generates, or propagates
  // a carry generated by the low part.
  always_comb begin
    g = g_hi | (p_hi & g_lo);
    p = p_hi & p_lo;
  end

endmodule

// File: rtl/kogge_stone_adder.sv
// N-bit unsigned adder with a Kogge-Stone carry network and a single
// registered output stage (sum, carry-out, valid).
module kogge_stone_adder
  import arith_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         out_valid
);

  localparam int unsigned STAGES = clog2_min0(N);

  // lvl[0] holds bit-level (g,p); lvl[k+1] is the output of prefix level k.
  // After the last level lvl[STAGES][i].g is the carry out of bit i.
  gp_t lvl [0:STAGES][0:N-1];

  logic [N-1:0] sum_c;
  logic         cout_c;
  logic         unused_final_p;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign lvl[0][i] = '{g: A[i] & B[i], p: A[i] ^ B[i]};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_level
    localparam int unsigned D = 1 << k;
    for (genvar i = 0; i < N; i++) begin : g_pos
      if (i >= D) begin : g_cell
        logic cg;
        logic cp;
        ks_prefix_cell u_cell (
          .g_hi (lvl[k][i].g),
          .p_hi (lvl[k][i].p),
          .g_lo (lvl[k][i-D].g),
          .p_lo (lvl[k][i-D].p),
          .g    (cg),
          .p    (cp)
        );
        assign lvl[k+1][i] = '{g: cg, p: cp};
      end else begin : g_pass
        assign lvl[k+1][i] = lvl[k][i];
      end
    end
  end

  // Sum bit i is its own propagate xored with the carry out of bit i-1;
  // bit 0 has no carry-in.
  always_comb begin
    sum_c    = '0;
    sum_c[0] = lvl[0][0].p;
    for (int unsigned i = 1; i < N; i++) begin
      sum_c[i] = lvl[0][i].p ^ lvl[STAGES][i-1].g;
    end
    cout_c = lvl[STAGES][N-1].g;
  end

  // Final-level group propagates are not needed for the sum; fold them
  // into one sink so every prefix output has a reader.
  always_comb begin
    unused_final_p = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      unused_final_p = unused_final_p ^ lvl[STAGES][i].p;
    end
  end

  // Output register: capture only qualified samples, hold otherwise;
  // valid follows in_valid with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_c;
        Cout <= cout_c;
      end
    end
  end

endmodule

// File: tb/tb_kogge_stone_adder.sv
// Directed and randomised checks of kogge_stone_adder at N=4, 1 and 13.
module tb_kogge_stone_adder;

  logic clk = 1'b0;
  logic rst;

  logic       iv4, ov4, co4;
  logic [3:0] a4, b4, s4;
  logic       iv1, ov1, co1;
  logic [0:0] a1, b1, s1;
  logic        iv13, ov13, co13;
  logic [12:0] a13, b13, s13;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kogge_stone_adder #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .A(a4), .B(b4),
    .Sum(s4), .Cout(co4), .out_valid(ov4)
  );

  kogge_stone_adder #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .A(a1), .B(b1),
    .Sum(s1), .Cout(co1), .out_valid(ov1)
  );

  kogge_stone_adder #(.N(13)) dut13 (
    .clk(clk), .rst(rst), .in_valid(iv13), .A(a13), .B(b13),
    .Sum(s13), .Cout(co13), .out_valid(ov13)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let the rising edge capture, sample 1 time unit later.
  task automatic cyc4(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst = r; iv4 = v; a4 = a; b4 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string name, input logic [3:0] s, input logic c, input logic v);
    chk({name, ".sum"}, 64'(s4), 64'(s));
    chk({name, ".cout"}, 64'(co4), 64'(c));
    chk({name, ".valid"}, 64'(ov4), 64'(v));
  endtask

  initial begin
    logic [3:0] ss [5];
    logic       cc [5];
    logic [3:0] sa, sb;
    logic [4:0] r5;
    logic [1:0] r2;
    logic [13:0] r14;
    logic [3:0] e_s4;  logic e_c4;  logic e_v4;
    logic [0:0] e_s1;  logic e_c1;  logic e_v1;
    logic [12:0] e_s13; logic e_c13; logic e_v13;
    logic rr;

    vecs[0] = '{a: 4'b1111, b: 4'b0001, sum: 4'b0000, cout: 1'b1};
    vecs[1] = '{a: 4'b1110, b: 4'b0001, sum: 4'b1111, cout: 1'b0};
    vecs[2] = '{a: 4'b1100, b: 4'b0011, sum: 4'b1111, cout: 1'b0};
    vecs[3] = '{a: 4'b1000, b: 4'b1000, sum: 4'b0000, cout: 1'b1};
    vecs[4] = '{a: 4'b1010, b: 4'b1101, sum: 4'b0111, cout: 1'b1};
    vecs[5] = '{a: 4'b1111, b: 4'b1111, sum: 4'b1110, cout: 1'b1};

    rst = 1'b1; iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    iv1 = 1'b0; a1 = '0; b1 = '0;
    iv13 = 1'b0; a13 = '0; b13 = '0;

    // Reset held with a valid operand pair present.
    cyc4(1'b1, 1'b1, 4'hF, 4'hF);
    cyc4(1'b1, 1'b1, 4'hF, 4'hF);
    chk4("reset", 4'h0, 1'b0, 1'b0);

    cyc4(1'b0, 1'b1, 4'h0, 4'h0);
    chk4("zero", 4'h0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      cyc4(1'b0, 1'b1, vecs[i].a, vecs[i].b);
      chk4($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, 1'b1);
    end

    // Five back-to-back operations, then two idle cycles.
    ss[0] = 4'h3; cc[0] = 1'b0;   // 1+2
    ss[1] = 4'h0; cc[1] = 1'b1;   // 9+7
    ss[2] = 4'hA; cc[2] = 1'b0;   // 5+5
    ss[3] = 4'hB; cc[3] = 1'b1;   // C+F
    ss[4] = 4'h6; cc[4] = 1'b0;   // 4+2
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin sa = 4'h1; sb = 4'h2; end
        1: begin sa = 4'h9; sb = 4'h7; end
        2: begin sa = 4'h5; sb = 4'h5; end
        3: begin sa = 4'hC; sb = 4'hF; end
        default: begin sa = 4'h4; sb = 4'h2; end
      endcase
      cyc4(1'b0, 1'b1, sa, sb);
      chk4($sformatf("stream%0d", i), ss[i], cc[i], 1'b1);
    end
    cyc4(1'b0, 1'b0, 4'hF, 4'hF);
    chk4("idle0", 4'h6, 1'b0, 1'b0);
    cyc4(1'b0, 1'b0, 4'h8, 4'h9);
    chk4("idle1", 4'h6, 1'b0, 1'b0);

    // Reset coinciding with a valid sample discards it.
    cyc4(1'b0, 1'b1, 4'hF, 4'hF);
    chk4("pre_rst", 4'hE, 1'b1, 1'b1);
    cyc4(1'b1, 1'b1, 4'hF, 4'h1);
    chk4("mid_rst", 4'h0, 1'b0, 1'b0);
    cyc4(1'b0, 1'b1, 4'h7, 4'h1);
    chk4("post_rst", 4'h8, 1'b0, 1'b1);

    // Randomised run over all three widths with occasional reset pulses.
    e_s4 = 4'h8; e_c4 = 1'b0; e_v4 = 1'b1;
    e_s1 = '0; e_c1 = 1'b0; e_v1 = 1'b0;
    e_s13 = '0; e_c13 = 1'b0; e_v13 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      rr = ($urandom_range(0, 19) == 0);
      rst = rr;
      iv4 = ($urandom_range(0, 3) != 0);
      iv1 = ($urandom_range(0, 3) != 0);
      iv13 = ($urandom_range(0, 3) != 0);
      a4 = 4'($urandom_range(0, 15));  b4 = 4'($urandom_range(0, 15));
      a1 = 1'($urandom_range(0, 1));   b1 = 1'($urandom_range(0, 1));
      a13 = 13'($urandom_range(0, 8191)); b13 = 13'($urandom_range(0, 8191));
      if (rr) begin
        e_s4 = '0; e_c4 = 1'b0; e_v4 = 1'b0;
        e_s1 = '0; e_c1 = 1'b0; e_v1 = 1'b0;
        e_s13 = '0; e_c13 = 1'b0; e_v13 = 1'b0;
      end else begin
        e_v4 = iv4; e_v1 = iv1; e_v13 = iv13;
        if (iv4) begin r5 = {1'b0, a4} + {1'b0, b4}; e_s4 = r5[3:0]; e_c4 = r5[4]; end
        if (iv1) begin r2 = {1'b0, a1} + {1'b0, b1}; e_s1 = r2[0:0]; e_c1 = r2[1]; end
        if (iv13) begin r14 = {1'b0, a13} + {1'b0, b13}; e_s13 = r14[12:0]; e_c13 = r14[13]; end
      end
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d.n4", n), {59'd0, ov4, co4, s4}, {59'd0, e_v4, e_c4, e_s4});
      chk($sformatf("rnd%0d.n1", n), {61'd0, ov1, co1, s1}, {61'd0, e_v1, e_c1, e_s1});
      chk($sformatf("rnd%0d.n13", n), {49'd0, ov13, co13, s13}, {49'd0, e_v13, e_c13, e_s13});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kogge_stone_adder.md
Name: kogge_stone_adder

Overview:
- Parameterised N-bit unsigned binary adder built on a Kogge-Stone parallel-prefix carry network.
- Sum and carry-out are registered: one clock, synchronous active-high reset.
- Used as a fast, fixed-latency arithmetic leaf wherever a datapath needs a low-depth carry chain.
- A valid strobe travels alongside the data so upstream and downstream logic can track results.

Parameters:
- N, 4, operand and sum width in bits; legal for any N >= 1.
- STAGES, derived as ceil(log2(N)) with 0 when N = 1; number of prefix levels; not user-overridable.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  qualifies A/B in the current cycle.
- A  input  N  unsigned operand A.
- B  input  N  unsigned operand B.
- Sum  output  N  registered low N bits of A+B.
- Cout  output  1  registered carry out of bit N-1, i.e. bit N of A+B.
- out_valid  output  1  high when Sum/Cout hold the result of an in_valid-qualified sample.

Behaviour:
- Reset: on a rising clk edge with rst=1, Sum = 0, Cout = 0 and out_valid = 0. rst has priority over in_valid.
- Bit-level signals: for each bit i, g_i = A_i & B_i and p_i = A_i ^ B_i. There is no carry-in; carry into bit 0 = 0.
- Prefix network:
  - Level k (k = 0..STAGES-1) combines span distance d = 2^k.
  - For i >= d: G = G_i | (P_i & G_{i-d}) and P = P_i & P_{i-d}.
  - For i < d: the pair passes through unchanged.
  - After the final level, G_i is the carry out of bit i.
- Sum and carry: Sum_i = p_i ^ c_{i-1}, with c_{-1} = 0. Cout = final G_{N-1}.
- The prefix network is purely combinational. It has exactly STAGES levels of black/grey cells and no internal registers.
- Latency is 1 cycle. A and B sampled at edge t give Sum/Cout valid after edge t, and out_valid = 1 in that same cycle.
- When in_valid = 0 at an edge:
  - Sum and Cout hold their previous values; no update.
  - out_valid goes to 0.
- Throughput: one new operation per cycle. Back-to-back in_valid produces back-to-back results with no bubbles.
- Width rules: arithmetic is unsigned modulo 2^N on Sum, and Cout is the overflow bit.
  - All-ones + 1 gives Sum = 0, Cout = 1.
  - All-ones + all-ones gives Sum = all-ones minus 1, Cout = 1.
- N = 1: STAGES = 0, so the block degenerates to a registered half adder (Sum = A^B, Cout = A&B).
- Reset mid-stream: rst asserted in the same cycle as in_valid discards that operand pair. Outputs read zero/invalid the next cycle.
- No X propagation: outputs are defined from the first post-reset cycle.

Decomposition:
- Shared package (arith_pkg):
  - function clog2_min0(N) used to compute STAGES.
  - typedef for the (G,P) pair struct.
- One natural sub-module, ks_prefix_cell:
  - Inputs: (G_hi, P_hi, G_lo, P_lo).
  - Outputs: (G = G_hi | P_hi&G_lo, P = P_hi&P_lo).
  - Instantiated in a generate grid of STAGES x N.
- Pass-through positions are plain wires, not cells.
- Output register and valid flop live in the top level.

Test Plan (N=4; each row: apply with in_valid=1, check Sum/Cout/out_valid one cycle later):
- Reset: hold rst=1 for 2 cycles with A=1111, B=1111, in_valid=1 -> Sum=0000, Cout=0, out_valid=0. Then 0000+0000 -> Sum=0000, Cout=0.
- Full carry ripple:
  - 1111+0001 -> Sum=0000, Cout=1.
  - 1110+0001 -> Sum=1111, Cout=0.
- No carries: 1100+0011 -> Sum=1111, Cout=0.
- MSB overflow and mixed:
  - 1000+1000 -> Sum=0000, Cout=1.
  - 1010+1101 -> Sum=0111, Cout=1.
- Streaming and hold:
  - Issue 5 back-to-back ops, then drop in_valid for 2 cycles -> results appear each cycle in order.
  - During the idle cycles, out_valid=0 and Sum/Cout keep the last result.
- Randomised self-check:
  - 1000 random pairs at N=4, N=1 and N=13 (non-power-of-2) against the reference {Cout,Sum} = A+B.
  - Include random rst pulses.
